// File: rtl/irq_exc_arbiter.sv
// irq_exc_arbiter: synchronises three external interrupt lines and collects
// ID/EXE exception flags, then issues one event at a time to cp0 (cause,
// interrupt level, return address). It tracks nested in-service levels on a
// small stack: push when an event is taken, pop on ERET. A new event is only
// issued once cp0 has acknowledged the previous one, or the ack wait times out.
//
// The in-service level register is the top of the level stack. The memory
// below it holds the STACK_DEPTH-1 saved levels beneath the current one.
module irq_exc_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int STACK_DEPTH = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  irq_in,
    input  logic [2:0]  irq_mask,
    input  logic        exc_undef,
    input  logic        exc_ovf,
    input  logic        exc_range,
    input  logic [31:0] exc_pc,
    input  logic [31:0] int_ret_pc,
    input  logic        ack,
    input  logic        eret,
    output logic [2:0]  cause,
    output logic [2:0]  interrupt_level,
    output logic [31:0] except_ret_addr,
    output logic        busy,
    output logic [2:0]  pending,
    output logic        err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int MEM_DEPTH = STACK_DEPTH - 1;
    localparam int SP_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int TMR_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(MEM_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] CAUSE_UNDEF = 3'b001;
    localparam logic [2:0] CAUSE_OVF   = 3'b010;
    localparam logic [2:0] CAUSE_RANGE = 3'b100;
    localparam logic [2:0] EXC_LEVEL   = 3'd3;

    // Interrupt synchroniser and edge detection
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  irq_synced;
    logic [2:0]                  irq_prev_q;
    logic [2:0]                  irq_rise;

    // Pending request latch
    logic [2:0] pend_q;
    logic [2:0] pend_d;
    logic [2:0] pend_clr;

    // Control state
    state_t          state_q, state_d;
    logic [2:0]      cur_q, cur_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic            err_q, err_d;
    logic [2:0]      cause_q, cause_d;
    logic [31:0]     ret_q, ret_d;

    // Saved-level memory and its write port
    logic [2:0]       stack_mem [MEM_DEPTH];
    logic             push_en;
    logic [IDX_W-1:0] push_idx;
    logic [2:0]       push_val;

    // Intermediate decisions
    logic [2:0]      lvl_pop;
    logic [SP_W-1:0] sp_pop;
    logic [2:0]      exc_code;
    logic            exc_any;
    logic            cand_vld;
    logic [1:0]      cand_idx;
    logic            take;
    logic [2:0]      take_lvl;

    assign irq_synced = sync_q[SYNC_STAGES-1];
    assign irq_rise   = irq_synced & ~irq_prev_q;
    assign pend_d     = (pend_q & ~pend_clr) | irq_rise;
    assign exc_any    = |exc_code;

    // Shift each irq line through the synchroniser and remember the last synced value
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (rst) begin
            sync_q     <= '0;
            irq_prev_q <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_in};
            irq_prev_q <= irq_synced;
        end
    end

    // Exception priority encode: undef beats ovf beats range
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        exc_code = 3'b000;
        if (exc_undef) begin
            exc_code = CAUSE_UNDEF;
        end else if (exc_ovf) begin
            exc_code = CAUSE_OVF;
        end else if (exc_range) begin
            exc_code = CAUSE_RANGE;
        end
    end

    // Highest enabled pending level strictly above the level now in service
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (pend_q[i] && irq_mask[i] && (3'(i + 1) > cur_q)) begin
                cand_vld = 1'b1;
                cand_idx = 2'(i);
            end
        end
    end

    // Next-state and datapath decisions: ERET pop first, then any event push
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        sp_d     = sp_q;
        tmr_d    = tmr_q;
        err_d    = err_q;
        cause_d  = 3'b000;
        ret_d    = ret_q;
        pend_clr = 3'b000;
        push_en  = 1'b0;
        push_idx = '0;
        push_val = 3'b000;
        lvl_pop  = cur_q;
        sp_pop   = sp_q;
        take     = 1'b0;
        take_lvl = 3'b000;

        // ERET is honoured in either state; popping an empty stack drops to level 0.
        if (eret) begin
            if (sp_q == '0) begin
                lvl_pop = 3'b000;
                err_d   = 1'b1;
            end else begin
                sp_pop  = sp_q - 1'b1;
                lvl_pop = stack_mem[IDX_W'(sp_q - 1'b1)];
            end
        end
        cur_d = lvl_pop;
        sp_d  = sp_pop;

        case (state_q)
            ST_IDLE: begin
                if (exc_any) begin
                    take     = 1'b1;
                    take_lvl = EXC_LEVEL;
                    cause_d  = exc_code;
                    ret_d    = exc_pc;
                end else if (cand_vld) begin
                    take     = 1'b1;
                    take_lvl = {1'b0, cand_idx} + 3'd1;
                    ret_d    = int_ret_pc;
                    pend_clr[cand_idx] = 1'b1;
                end
                if (take) begin
                    state_d = ST_WAIT;
                    tmr_d   = '0;
                    cur_d   = take_lvl;
                    // A full stack drops the saved level but the new level still takes effect.
                    if (sp_pop == SP_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        push_en  = 1'b1;
                        push_idx = IDX_W'(sp_pop);
                        push_val = lvl_pop;
                        sp_d     = sp_pop + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Exception flags seen here belong to flushed instructions and are ignored.
                if (ack) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= 3'b000;
            sp_q    <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            cause_q <= 3'b000;
            ret_q   <= 32'h0;
            pend_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            sp_q    <= sp_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            cause_q <= cause_d;
            ret_q   <= ret_d;
            pend_q  <= pend_d;
        end
    end

    // Saved-level memory write
    always_ff @(posedge clk) begin
        // NOTE: the memory is not reset; the stack pointer reset empties it and nothing reads above it.
        if (push_en) begin
            stack_mem[push_idx] <= push_val;
        end
    end

    assign cause           = cause_q;
    assign interrupt_level = cur_q;
    assign except_ret_addr = ret_q;
    assign busy            = (state_q == ST_WAIT);
    assign pending         = pend_q;
    assign err             = err_q;

endmodule

// File: tb/tb_irq_exc_arbiter.sv
// Testbench for irq_exc_arbiter: expected events are queued as stimulus is
// applied and compared when the DUT raises busy; level, error and pending
// behaviour is checked directly between events.
module tb_irq_exc_arbiter;

    localparam int ACK_TIMEOUT = 8;
    localparam int WAIT_LIMIT  = 20;

    typedef struct packed {
        logic [2:0]  level;
        logic [31:0] addr;
        logic [2:0]  cause;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_in;
    logic [2:0]  irq_mask;
    logic        exc_undef;
    logic        exc_ovf;
    logic        exc_range;
    logic [31:0] exc_pc;
    logic [31:0] int_ret_pc;
    logic        ack;
    logic        eret;
    logic [2:0]  cause;
    logic [2:0]  interrupt_level;
    logic [31:0] except_ret_addr;
    logic        busy;
    logic [2:0]  pending;
    logic        err;

    ev_t  sb_q[$];
    ev_t  exp_ev;
    logic busy_prev;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    irq_exc_arbiter #(
        .SYNC_STAGES(2),
        .STACK_DEPTH(4),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_in         (irq_in),
        .irq_mask       (irq_mask),
        .exc_undef      (exc_undef),
        .exc_ovf        (exc_ovf),
        .exc_range      (exc_range),
        .exc_pc         (exc_pc),
        .int_ret_pc     (int_ret_pc),
        .ack            (ack),
        .eret           (eret),
        .cause          (cause),
        .interrupt_level(interrupt_level),
        .except_ret_addr(except_ret_addr),
        .busy           (busy),
        .pending        (pending),
        .err            (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_event(input logic [2:0] lvl, input logic [31:0] addr, input logic [2:0] cse);
        ev_t e;
        e.level = lvl;
        e.addr  = addr;
        e.cause = cse;
        sb_q.push_back(e);
    endtask

    task automatic wait_busy(input string tag);
        int cnt = 0;
        while (!busy && cnt < WAIT_LIMIT) begin
            tick(1);
            cnt++;
        end
        check(tag, 32'(busy), 32'd1);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
    endtask

    // Event monitor: compare each newly issued event against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            busy_prev <= 1'b0;
        end else begin
            if (busy && !busy_prev) begin
                check("ev_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_ev = sb_q.pop_front();
                    check("ev_level", 32'(interrupt_level), 32'(exp_ev.level));
                    check("ev_addr", except_ret_addr, exp_ev.addr);
                    check("ev_cause", 32'(cause), 32'(exp_ev.cause));
                end
            end else if (busy && busy_prev) begin
                check("wait_cause_zero", 32'(cause), 32'd0);
            end
            busy_prev <= busy;
        end
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    // Directed sequence
    initial begin
        logic found;
        int   cnt;

        rst        = 1'b1;
        irq_in     = 3'b000;
        irq_mask   = 3'b000;
        exc_undef  = 1'b0;
        exc_ovf    = 1'b0;
        exc_range  = 1'b0;
        exc_pc     = 32'h0;
        int_ret_pc = 32'h0;
        ack        = 1'b0;
        eret       = 1'b0;
        tick(2);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_level", 32'(interrupt_level), 32'd0);
        check("rst_addr", except_ret_addr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Single interrupt on level 2, acknowledged
        irq_mask   = 3'b111;
        int_ret_pc = 32'h0000_0100;
        expect_event(3'd2, 32'h0000_0100, 3'b000);
        irq_in = 3'b010;
        found  = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            tick(1);
            if (pending[1]) found = 1'b1;
        end
        check("t1_pending_set", 32'(found), 32'd1);
        wait_busy("t1_issue");
        check("t1_pending_taken", 32'(pending), 32'd0);
        exc_undef = 1'b1;
        tick(1);
        exc_undef = 1'b0;
        check("t1_busy_hold", 32'(busy), 32'd1);
        check("t1_exc_ignored", 32'(cause), 32'd0);
        pulse_ack();
        check("t1_ack_busy", 32'(busy), 32'd0);
        check("t1_ack_level", 32'(interrupt_level), 32'd2);
        tick(4);
        check("t1_no_rearm", 32'(pending), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        irq_in = 3'b000;

        // Simultaneous exceptions: undef wins, one-cycle cause
        exc_pc = 32'h0000_0040;
        expect_event(3'd3, 32'h0000_0040, 3'b001);
        exc_ovf   = 1'b1;
        exc_undef = 1'b1;
        tick(1);
        exc_ovf   = 1'b0;
        exc_undef = 1'b0;
        check("t2_cause", 32'(cause), 32'd1);
        check("t2_addr", except_ret_addr, 32'h0000_0040);
        tick(1);
        check("t2_cause_once", 32'(cause), 32'd0);
        pulse_ack();
        pulse_eret();
        check("t2_eret1", 32'(interrupt_level), 32'd2);
        pulse_eret();
        check("t2_eret2", 32'(interrupt_level), 32'd0);

        // Lower level stays pending until ERET drops below it
        int_ret_pc = 32'h0000_0200;
        expect_event(3'd2, 32'h0000_0200, 3'b000);
        irq_in = 3'b010;
        wait_busy("t3_issue2");
        pulse_ack();
        irq_in = 3'b011;
        tick(5);
        check("t3_held_pending", 32'(pending), 32'd1);
        check("t3_held_level", 32'(interrupt_level), 32'd2);
        check("t3_held_idle", 32'(busy), 32'd0);
        int_ret_pc = 32'h0000_0300;
        expect_event(3'd1, 32'h0000_0300, 3'b000);
        pulse_eret();
        check("t3_eret_level", 32'(interrupt_level), 32'd0);
        wait_busy("t3_issue1");
        pulse_ack();
        pulse_eret();
        check("t3_back_to_0", 32'(interrupt_level), 32'd0);
        irq_in = 3'b000;
        tick(1);

        // Nesting 1 -> 2 -> 3, then an overflowing fourth push
        for (int k = 0; k < 3; k++) begin
            int_ret_pc = 32'h0000_0400 + 32'(k * 4);
            expect_event(3'(k + 1), 32'h0000_0400 + 32'(k * 4), 3'b000);
            irq_in[k] = 1'b1;
            wait_busy("t4_nest_issue");
            check("t4_nest_level", 32'(interrupt_level), 32'(k + 1));
            pulse_ack();
        end
        check("t4_err_before_full", 32'(err), 32'd0);
        exc_pc = 32'h0000_0500;
        expect_event(3'd3, 32'h0000_0500, 3'b010);
        exc_ovf = 1'b1;
        tick(1);
        exc_ovf = 1'b0;
        check("t4_overflow_err", 32'(err), 32'd1);
        check("t4_overflow_level", 32'(interrupt_level), 32'd3);
        pulse_ack();
        for (int k = 0; k < 3; k++) begin
            pulse_eret();
            check("t4_unwind_level", 32'(interrupt_level), 32'(2 - k));
        end
        pulse_eret();
        check("t4_underflow_level", 32'(interrupt_level), 32'd0);
        check("t4_underflow_err", 32'(err), 32'd1);
        irq_in = 3'b000;

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst2_err", 32'(err), 32'd0);
        check("rst2_level", 32'(interrupt_level), 32'd0);

        // Ack timeout abandons the event; the push stands
        int_ret_pc = 32'h0000_0600;
        expect_event(3'd3, 32'h0000_0600, 3'b000);
        irq_in = 3'b100;
        wait_busy("t5_issue");
        cnt = 0;
        while (busy && cnt < WAIT_LIMIT) begin
            tick(1);
            cnt++;
        end
        check("t5_timeout_len", 32'(cnt), 32'(ACK_TIMEOUT));
        check("t5_timeout_err", 32'(err), 32'd1);
        check("t5_timeout_level", 32'(interrupt_level), 32'd3);
        exc_pc = 32'h0000_0080;
        expect_event(3'd3, 32'h0000_0080, 3'b100);
        exc_range = 1'b1;
        tick(1);
        exc_range = 1'b0;
        check("t5_next_busy", 32'(busy), 32'd1);
        pulse_ack();
        check("t5_next_done", 32'(busy), 32'd0);
        pulse_eret();
        check("t5_pop_exc", 32'(interrupt_level), 32'd3);
        pulse_eret();
        check("t5_pop_irq", 32'(interrupt_level), 32'd0);
        irq_in = 3'b000;
        tick(1);

        // Reset while waiting for ack with pending requests
        int_ret_pc = 32'h0000_0700;
        expect_event(3'd2, 32'h0000_0700, 3'b000);
        irq_in = 3'b010;
        wait_busy("t6_issue");
        irq_in = 3'b111;
        tick(4);
        check("t6_pending", 32'(pending), 32'd5);
        check("t6_busy", 32'(busy), 32'd1);
        rst    = 1'b1;
        irq_in = 3'b000;
        tick(1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_pending_lost", 32'(pending), 32'd0);
        check("t6_level", 32'(interrupt_level), 32'd0);
        check("t6_addr", except_ret_addr, 32'd0);
        check("t6_cause", 32'(cause), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick(4);
        check("t6_quiet", 32'(pending), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
